cp0_ext: RTL and testbench

- Parametrised second-generation coprocessor-0 register file for the MIPS core.
- Adds four features:
  - configurable Count prescaler;
  - Compare/timer interrupt merged into Cause.IP7 with a Cause.TI bit;
  - registered interrupt-pending evaluation;
  - exception/ERET target-address generation (BEV/EBase/IV vectoring) and ErrorEPC.
- Sits beside the MEM/WB stages: MTC0 writes arrive at WB, exceptions and ERET arrive at MEM.

---
 rtl/cp0_ext_if.sv | 37 +++
 rtl/cp0_ext.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cp0_ext.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_ext_if.sv
// cp0_ext_if: pipeline-side bus of the coprocessor-0 register file.
// Carries the MFC0 read port, the MTC0 write port (WB stage) and the
// exception/ERET request with its redirect target (MEM stage).
interface cp0_ext_if;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;

  logic        we;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;

  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_delayslot;
  logic [31:0] exc_badva;
  logic [31:0] exc_target;

  // Pipeline side: issues reads, writes and exception requests.
  modport master (
    output rd_addr, rd_sel,
    output we, wr_addr, wr_sel, wr_data,
    output exc_valid, exc_eret, exc_code, exc_pc, exc_delayslot, exc_badva,
    input  rd_data, exc_target
  );

  // CP0 side: serves reads and computes the redirect target.
  modport slave (
    input  rd_addr, rd_sel,
    input  we, wr_addr, wr_sel, wr_data,
    input  exc_valid, exc_eret, exc_code, exc_pc, exc_delayslot, exc_badva,
    output rd_data, exc_target
  );
endinterface

// File: rtl/cp0_ext.sv
// cp0_ext: second-generation coprocessor-0 register file for the MIPS core.
// Holds the TLB helper registers, a prescaled Count/Compare timer folded into
// Cause.IP7/TI, a registered interrupt-pending flag, and generates the
// exception/ERET redirect address with BEV/EBase/IV vectoring.
// Update order inside one cycle: free-running updates, then MTC0, then
// exception/ERET, so a later stage always overrides an earlier one.
module cp0_ext #(
  parameter int          N_TLB_ENTRIES = 32,
  parameter int          COUNT_DIV     = 2,
  parameter int          N_HW_INT      = 6,
  parameter logic [31:0] RESET_EBASE   = 32'h8000_0000,
  localparam int         TLB_WIDTH     = $clog2(N_TLB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_ext_if.slave             bus,
  input  logic [N_HW_INT-1:0]  hw_int,
  input  logic                 tlbwr,
  output logic                 int_pending,
  output logic                 timer_int,
  output logic                 user_mode,
  output logic [TLB_WIDTH-1:0] random_idx
);

  localparam int                   PRE_W        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRE_W-1:0]     PRE_MAX      = PRE_W'(COUNT_DIV - 1);
  localparam logic [TLB_WIDTH-1:0] RANDOM_MAX   = TLB_WIDTH'(N_TLB_ENTRIES - 1);
  localparam logic [31:0]          STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0]          STATUS_WMASK = 32'h1040_FF17;
  localparam logic [31:0]          EBASE_WMASK  = 32'h3FFF_F000;

  // Architectural state
  logic [TLB_WIDTH-1:0] index_q, index_n;
  logic [TLB_WIDTH-1:0] random_q, random_n;
  logic [29:0]          entrylo0_q, entrylo0_n;
  logic [29:0]          entrylo1_q, entrylo1_n;
  logic [TLB_WIDTH-1:0] wired_q, wired_n;
  logic [31:0]          badvaddr_q, badvaddr_n;
  logic [31:0]          count_q, count_n;
  logic [PRE_W-1:0]     pre_q, pre_n;
  logic [31:0]          compare_q, compare_n;
  logic [31:0]          status_q, status_n;
  logic                 bd_q, bd_n;
  logic                 iv_q, iv_n;
  logic [1:0]           sw_ip_q, sw_ip_n;
  logic [7:2]           hw_ip_q, hw_ip_n;
  logic [4:0]           exccode_q, exccode_n;
  logic [31:0]          epc_q, epc_n;
  logic [31:0]          ebase_q, ebase_n;
  logic [31:0]          errorepc_q, errorepc_n;
  logic                 timer_q, timer_n;
  logic                 int_pending_q, int_pending_n;

  // Decoded MTC0 targets
  logic wr_sel0;
  logic wr_index, wr_entrylo0, wr_entrylo1, wr_wired, wr_count, wr_compare;
  logic wr_status, wr_cause, wr_epc, wr_ebase, wr_errorepc;

  // Exception helpers
  logic        exc_take;
  logic        exc_ret;
  logic        exc_addr_err;
  logic [7:0]  ip_n;
  logic [7:0]  cause_ip;
  logic [31:0] cause_rd;
  logic [31:0] vec_base;
  logic [31:0] vec_off;

  assign wr_sel0     = bus.we && (bus.wr_sel == 3'd0);
  assign wr_index    = wr_sel0 && (bus.wr_addr == 5'd0);
  assign wr_entrylo0 = wr_sel0 && (bus.wr_addr == 5'd2);
  assign wr_entrylo1 = wr_sel0 && (bus.wr_addr == 5'd3);
  assign wr_wired    = wr_sel0 && (bus.wr_addr == 5'd6);
  assign wr_count    = wr_sel0 && (bus.wr_addr == 5'd9);
  assign wr_compare  = wr_sel0 && (bus.wr_addr == 5'd11);
  assign wr_status   = wr_sel0 && (bus.wr_addr == 5'd12);
  assign wr_cause    = wr_sel0 && (bus.wr_addr == 5'd13);
  assign wr_epc      = wr_sel0 && (bus.wr_addr == 5'd14);
  assign wr_ebase    = bus.we && (bus.wr_sel == 3'd1) && (bus.wr_addr == 5'd15);
  assign wr_errorepc = wr_sel0 && (bus.wr_addr == 5'd30);

  assign exc_take = bus.exc_valid && !bus.exc_eret;
  assign exc_ret  = bus.exc_valid && bus.exc_eret;

  // Address-error and TLB exceptions latch the faulting virtual address.
  always_comb begin
    case (bus.exc_code)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5: exc_addr_err = 1'b1;
      default:                      exc_addr_err = 1'b0;
    endcase
  end

  // Next-state evaluation: free-running updates, then MTC0, then exception/ERET.
  always_comb begin
    index_n    = index_q;
    random_n   = random_q;
    entrylo0_n = entrylo0_q;
    entrylo1_n = entrylo1_q;
    wired_n    = wired_q;
    badvaddr_n = badvaddr_q;
    count_n    = count_q;
    pre_n      = pre_q;
    compare_n  = compare_q;
    status_n   = status_q;
    bd_n       = bd_q;
    iv_n       = iv_q;
    sw_ip_n    = sw_ip_q;
    exccode_n  = exccode_q;
    epc_n      = epc_q;
    ebase_n    = ebase_q;
    errorepc_n = errorepc_q;
    timer_n    = timer_q;

    if (pre_q == PRE_MAX) begin
      pre_n   = '0;
      count_n = count_q + 32'd1;
    end else begin
      pre_n = pre_q + PRE_W'(1);
    end

    if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_n = 1'b1;
    end

    hw_ip_n = '0;
    hw_ip_n[2 +: N_HW_INT] = hw_int;

    if (tlbwr) begin
      if ((wired_q >= RANDOM_MAX) || (random_q == wired_q)) begin
        random_n = RANDOM_MAX;
      end else begin
        random_n = random_q - TLB_WIDTH'(1);
      end
    end

    if (wr_index) begin
      index_n = bus.wr_data[TLB_WIDTH-1:0];
    end
    if (wr_entrylo0) begin
      entrylo0_n = bus.wr_data[29:0];
    end
    if (wr_entrylo1) begin
      entrylo1_n = bus.wr_data[29:0];
    end
    if (wr_wired) begin
      wired_n  = bus.wr_data[TLB_WIDTH-1:0];
      random_n = RANDOM_MAX;
    end
    if (wr_count) begin
      count_n = bus.wr_data;
      pre_n   = '0;
    end
    if (wr_compare) begin
      compare_n = bus.wr_data;
      timer_n   = 1'b0;
    end
    if (wr_status) begin
      status_n = (status_q & ~STATUS_WMASK) | (bus.wr_data & STATUS_WMASK);
    end
    if (wr_cause) begin
      iv_n    = bus.wr_data[23];
      sw_ip_n = bus.wr_data[9:8];
    end
    if (wr_epc) begin
      epc_n = bus.wr_data;
    end
    if (wr_ebase) begin
      ebase_n = (ebase_q & ~EBASE_WMASK) | (bus.wr_data & EBASE_WMASK);
    end
    if (wr_errorepc) begin
      errorepc_n = bus.wr_data;
    end

    if (exc_take) begin
      if (!status_n[1]) begin
        epc_n = bus.exc_pc - (bus.exc_delayslot ? 32'd4 : 32'd0);
        bd_n  = bus.exc_delayslot;
      end
      status_n[1] = 1'b1;
      exccode_n   = bus.exc_code;
      if (exc_addr_err) begin
        badvaddr_n = bus.exc_badva;
      end
    end else if (exc_ret) begin
      if (status_n[2]) begin
        status_n[2] = 1'b0;
      end else begin
        status_n[1] = 1'b0;
      end
    end

    ip_n = {hw_ip_n[7] | timer_n, hw_ip_n[6:2], sw_ip_n};
    int_pending_n = status_n[0] && !status_n[1] && !status_n[2] &&
                    ((ip_n & status_n[15:8]) != 8'd0);
  end

  // State registers with synchronous reset; inputs are ignored in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q       <= '0;
      random_q      <= RANDOM_MAX;
      entrylo0_q    <= '0;
      entrylo1_q    <= '0;
      wired_q       <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      pre_q         <= '0;
      compare_q     <= '0;
      status_q      <= STATUS_RESET;
      bd_q          <= 1'b0;
      iv_q          <= 1'b0;
      sw_ip_q       <= '0;
      hw_ip_q       <= '0;
      exccode_q     <= '0;
      epc_q         <= '0;
      ebase_q       <= RESET_EBASE;
      errorepc_q    <= '0;
      timer_q       <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      index_q       <= index_n;
      random_q      <= random_n;
      entrylo0_q    <= entrylo0_n;
      entrylo1_q    <= entrylo1_n;
      wired_q       <= wired_n;
      badvaddr_q    <= badvaddr_n;
      count_q       <= count_n;
      pre_q         <= pre_n;
      compare_q     <= compare_n;
      status_q      <= status_n;
      bd_q          <= bd_n;
      iv_q          <= iv_n;
      sw_ip_q       <= sw_ip_n;
      hw_ip_q       <= hw_ip_n;
      exccode_q     <= exccode_n;
      epc_q         <= epc_n;
      ebase_q       <= ebase_n;
      errorepc_q    <= errorepc_n;
      timer_q       <= timer_n;
      int_pending_q <= int_pending_n;
    end
  end

  assign cause_ip = {hw_ip_q[7] | timer_q, hw_ip_q[6:2], sw_ip_q};
  assign cause_rd = {bd_q, timer_q, 6'b0, iv_q, 7'b0, cause_ip, 1'b0, exccode_q, 2'b0};

  // MFC0 read mux; unmapped register selects return zero.
  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_sel == 3'd0) begin
      case (bus.rd_addr)
        5'd0:    bus.rd_data = 32'(index_q);
        5'd1:    bus.rd_data = 32'(random_q);
        5'd2:    bus.rd_data = {2'b0, entrylo0_q};
        5'd3:    bus.rd_data = {2'b0, entrylo1_q};
        5'd6:    bus.rd_data = 32'(wired_q);
        5'd8:    bus.rd_data = badvaddr_q;
        5'd9:    bus.rd_data = count_q;
        5'd11:   bus.rd_data = compare_q;
        5'd12:   bus.rd_data = status_q;
        5'd13:   bus.rd_data = cause_rd;
        5'd14:   bus.rd_data = epc_q;
        5'd30:   bus.rd_data = errorepc_q;
        default: bus.rd_data = '0;
      endcase
    end else if ((bus.rd_sel == 3'd1) && (bus.rd_addr == 5'd15)) begin
      bus.rd_data = ebase_q;
    end
  end

  // Redirect target: ERET returns to ErrorEPC/EPC, exceptions go to the vector.
  always_comb begin
    vec_base       = status_q[22] ? 32'hBFC0_0200 : {ebase_q[31:12], 12'h000};
    vec_off        = ((bus.exc_code == 5'd0) && iv_q) ? 32'h0000_0200 : 32'h0000_0180;
    bus.exc_target = '0;
    if (bus.exc_valid) begin
      if (bus.exc_eret) begin
        bus.exc_target = status_q[2] ? errorepc_q : epc_q;
      end else begin
        bus.exc_target = vec_base + vec_off;
      end
    end
  end

  assign int_pending = int_pending_q;
  assign timer_int   = timer_q;
  assign user_mode   = (status_q[4:1] == 4'b1000);
  assign random_idx  = random_q;

endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed bench for cp0_ext with an architectural reference model.
// The model tracks register contents from the stimulus (Count as load value plus
// elapsed cycles / divider) and a compare process checks every output each cycle;
// directed steps additionally pin hand-computed literal values.
module tb_cp0_ext;
  localparam int N   = 32;
  localparam int DIV = 2;
  localparam int NHW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NHW-1:0] hw_int = '0;
  logic           tlbwr = 1'b0;
  logic           int_pending;
  logic           timer_int;
  logic           user_mode;
  logic [4:0]     random_idx;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_ext_if bus();

  cp0_ext #(
    .N_TLB_ENTRIES(N),
    .COUNT_DIV(DIV),
    .N_HW_INT(NHW),
    .RESET_EBASE(32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .hw_int(hw_int),
    .tlbwr(tlbwr),
    .int_pending(int_pending),
    .timer_int(timer_int),
    .user_mode(user_mode),
    .random_idx(random_idx)
  );

  // 20 ns clock; rising edge is active
  always #10 clk = ~clk;

  // Reference model state
  bit          m_valid = 1'b0;
  int          m_index, m_random, m_wired;
  logic [31:0] m_el0, m_el1, m_badva, m_cbase, m_compare, m_status;
  logic [31:0] m_epc, m_ebase, m_errorepc;
  int unsigned m_cycles;
  logic        m_bd, m_iv, m_timer, m_intp;
  logic [1:0]  m_swip;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_cycles / DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip      = '0;
    ip[1:0] = m_swip;
    ip[6:2] = m_hw[4:0];
    ip[7]   = m_hw[5] | m_timer;
    return ip;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    logic [31:0] c;
    if (s == 3'd1 && a == 5'd15) return m_ebase;
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd0:  return 32'(m_index);
      5'd1:  return 32'(m_random);
      5'd2:  return m_el0;
      5'd3:  return m_el1;
      5'd6:  return 32'(m_wired);
      5'd8:  return m_badva;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: begin
        c       = '0;
        c[31]   = m_bd;
        c[30]   = m_timer;
        c[23]   = m_iv;
        c[15:8] = m_ip();
        c[6:2]  = m_code;
        return c;
      end
      5'd14: return m_epc;
      5'd30: return m_errorepc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] base;
    if (!bus.exc_valid) return 32'd0;
    if (bus.exc_eret) return m_status[2] ? m_errorepc : m_epc;
    base = m_status[22] ? 32'hBFC0_0200 : {m_ebase[31:12], 12'h000};
    return base + ((bus.exc_code == 5'd0 && m_iv) ? 32'h200 : 32'h180);
  endfunction

  task automatic model_step();
    logic [31:0] cnt_old;
    if (rst) begin
      m_index = 0; m_random = N - 1; m_wired = 0;
      m_el0 = 0; m_el1 = 0; m_badva = 0; m_cbase = 0; m_cycles = 0; m_compare = 0;
      m_status = 32'h0040_0004; m_bd = 0; m_iv = 0; m_swip = 0; m_hw = 0; m_code = 0;
      m_epc = 0; m_ebase = 32'h8000_0000; m_errorepc = 0; m_timer = 0; m_intp = 0;
      m_valid = 1'b1;
      return;
    end
    cnt_old = m_count();
    m_cycles++;
    if (cnt_old == m_compare && m_compare != 0) m_timer = 1'b1;
    m_hw = hw_int;
    if (tlbwr) begin
      if (m_wired >= N - 1 || m_random == m_wired) m_random = N - 1;
      else m_random = m_random - 1;
    end
    if (bus.we && bus.wr_sel == 3'd0) begin
      case (bus.wr_addr)
        5'd0:  m_index = int'(bus.wr_data[4:0]);
        5'd2:  m_el0 = bus.wr_data & 32'h3FFF_FFFF;
        5'd3:  m_el1 = bus.wr_data & 32'h3FFF_FFFF;
        5'd6:  begin m_wired = int'(bus.wr_data[4:0]); m_random = N - 1; end
        5'd9:  begin m_cbase = bus.wr_data; m_cycles = 0; end
        5'd11: begin m_compare = bus.wr_data; m_timer = 1'b0; end
        5'd12: m_status = bus.wr_data & 32'h1040_FF17;
        5'd13: begin m_iv = bus.wr_data[23]; m_swip = bus.wr_data[9:8]; end
        5'd14: m_epc = bus.wr_data;
        5'd30: m_errorepc = bus.wr_data;
        default: ;
      endcase
    end else if (bus.we && bus.wr_sel == 3'd1 && bus.wr_addr == 5'd15) begin
      m_ebase = {m_ebase[31:30], bus.wr_data[29:12], m_ebase[11:0]};
    end
    if (bus.exc_valid) begin
      if (bus.exc_eret) begin
        if (m_status[2]) m_status[2] = 1'b0;
        else m_status[1] = 1'b0;
      end else begin
        if (!m_status[1]) begin
          m_epc = bus.exc_delayslot ? bus.exc_pc - 32'd4 : bus.exc_pc;
          m_bd  = bus.exc_delayslot;
        end
        m_status[1] = 1'b1;
        m_code = bus.exc_code;
        if (bus.exc_code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) m_badva = bus.exc_badva;
      end
    end
    m_intp = m_status[0] && !m_status[1] && !m_status[2] && ((m_ip() & m_status[15:8]) != 8'd0);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every active edge using the inputs held across it
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: all outputs against the model on every falling edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check_output("int_pending", 32'(int_pending), 32'(m_intp));
      check_output("timer_int", 32'(timer_int), 32'(m_timer));
      check_output("random_idx", 32'(random_idx), 32'(m_random));
      check_output("user_mode", 32'(user_mode), 32'(m_status[4:1] == 4'b1000));
      check_output("rd_data", bus.rd_data, m_read(bus.rd_addr, bus.rd_sel));
      check_output("exc_target", bus.exc_target, m_target());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.we = 1'b1; bus.wr_addr = a; bus.wr_sel = s; bus.wr_data = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] exp);
    bus.rd_addr = a; bus.rd_sel = s;
    #1;
    check_output(name, bus.rd_data, exp);
  endtask

  task automatic set_exc(input logic v, input logic eret, input logic [4:0] code,
                         input logic [31:0] pc, input logic ds, input logic [31:0] badva);
    bus.exc_valid = v; bus.exc_eret = eret; bus.exc_code = code;
    bus.exc_pc = pc; bus.exc_delayslot = ds; bus.exc_badva = badva;
  endtask

  initial begin
    bus.rd_addr = 5'd12; bus.rd_sel = 3'd0;
    bus.we = 1'b0; bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_data = '0;
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    read_check("status_reset", 5'd12, 3'd0, 32'h0040_0004);
    read_check("ebase_reset", 5'd15, 3'd1, 32'h8000_0000);
    read_check("random_reset", 5'd1, 3'd0, 32'd31);
    check_output("random_idx_reset", 32'(random_idx), 32'd31);
    check_output("int_pending_reset", 32'(int_pending), 32'd0);
    tick();

    // Prescaled Count and Compare match
    apply_stimulus(5'd9, 3'd0, 32'd0);
    apply_stimulus(5'd11, 3'd0, 32'd3);
    bus.rd_addr = 5'd9;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_output("count_step", bus.rd_data, 32'((i + 1) / 2));
      check_output("timer_step", 32'(timer_int), 32'(i >= 6));
    end
    read_check("count_after_10", 5'd9, 3'd0, 32'd5);
    bus.rd_addr = 5'd13; #1;
    check_output("cause_ti", 32'(bus.rd_data[30]), 32'd1);
    apply_stimulus(5'd11, 3'd0, 32'd100);
    check_output("timer_cleared", 32'(timer_int), 32'd0);

    // Timer interrupt through IM7/IE, then masked by EXL
    apply_stimulus(5'd12, 3'd0, 32'h0000_8001);
    apply_stimulus(5'd9, 3'd0, 32'd0);
    apply_stimulus(5'd11, 3'd0, 32'd2);
    repeat (6) tick();
    check_output("timer_fired", 32'(timer_int), 32'd1);
    check_output("int_pending_timer", 32'(int_pending), 32'd1);
    set_exc(1'b1, 1'b0, 5'd4, 32'h8000_1004, 1'b1, 32'h0000_1233);
    #1;
    check_output("target_exc4", bus.exc_target, 32'h8000_0180);
    tick();
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    check_output("int_pending_exl", 32'(int_pending), 32'd0);
    read_check("epc_ds", 5'd14, 3'd0, 32'h8000_1000);
    read_check("badvaddr", 5'd8, 3'd0, 32'h0000_1233);
    bus.rd_addr = 5'd13; #1;
    check_output("cause_bd", 32'(bus.rd_data[31]), 32'd1);
    read_check("status_exl", 5'd12, 3'd0, 32'h0000_8003);
    tick();
    set_exc(1'b1, 1'b0, 5'd8, 32'h8000_2000, 1'b0, 32'h0000_DEAD);
    tick();
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    read_check("epc_nested", 5'd14, 3'd0, 32'h8000_1000);
    read_check("badvaddr_kept", 5'd8, 3'd0, 32'h0000_1233);
    bus.rd_addr = 5'd13; #1;
    check_output("exccode_8", 32'(bus.rd_data[6:2]), 32'd8);

    // EBase/IV vectoring and ERET via ErrorEPC
    apply_stimulus(5'd15, 3'd1, 32'h8000_3000);
    apply_stimulus(5'd13, 3'd0, 32'h0080_0000);
    set_exc(1'b1, 1'b0, 5'd0, 32'h8000_5000, 1'b0, 32'd0);
    #1;
    check_output("target_iv", bus.exc_target, 32'h8000_3200);
    bus.exc_code = 5'd8;
    #1;
    check_output("target_general", bus.exc_target, 32'h8000_3180);
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    apply_stimulus(5'd30, 3'd0, 32'hBFC0_0000);
    apply_stimulus(5'd12, 3'd0, 32'h0000_8007);
    set_exc(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0);
    #1;
    check_output("target_eret_erl", bus.exc_target, 32'hBFC0_0000);
    tick();
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    read_check("status_erl_clr", 5'd12, 3'd0, 32'h0000_8003);

    // Wired/Random walk
    apply_stimulus(5'd6, 3'd0, 32'd30);
    check_output("random_wired", 32'(random_idx), 32'd31);
    tlbwr = 1'b1;
    tick(); check_output("random_1", 32'(random_idx), 32'd30);
    tick(); check_output("random_2", 32'(random_idx), 32'd31);
    tick(); check_output("random_3", 32'(random_idx), 32'd30);
    tlbwr = 1'b0;

    // ERET clears EXL, then exception beats a same-cycle MTC0 EPC
    set_exc(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0);
    tick();
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    read_check("status_exl_clr", 5'd12, 3'd0, 32'h0000_8001);
    set_exc(1'b1, 1'b0, 5'd10, 32'h8000_4000, 1'b0, 32'd0);
    apply_stimulus(5'd14, 3'd0, 32'h1234_5678);
    set_exc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    read_check("epc_exc_wins", 5'd14, 3'd0, 32'h8000_4000);

    // Hardware interrupt line 0 through IM2, and user mode
    apply_stimulus(5'd12, 3'd0, 32'h0000_0401);
    hw_int = 6'b000001;
    tick();
    check_output("int_pending_hw", 32'(int_pending), 32'd1);
    bus.rd_addr = 5'd13; #1;
    check_output("cause_ip2", 32'(bus.rd_data[10]), 32'd1);
    hw_int = '0;
    tick();
    check_output("int_pending_hw_off", 32'(int_pending), 32'd0);
    apply_stimulus(5'd12, 3'd0, 32'h0000_0010);
    check_output("user_mode", 32'(user_mode), 32'd1);

    // Reset in the middle of activity, with a write and tlbwr that must be ignored
    rst = 1'b1; tlbwr = 1'b1;
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_sel = 3'd0; bus.wr_data = 32'h1000_0000;
    tick();
    rst = 1'b0; tlbwr = 1'b0; bus.we = 1'b0;
    read_check("status_rst2", 5'd12, 3'd0, 32'h0040_0004);
    read_check("count_rst2", 5'd9, 3'd0, 32'd0);
    check_output("random_rst2", 32'(random_idx), 32'd31);
    check_output("timer_rst2", 32'(timer_int), 32'd0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
